sr_cmd_gen: RTL

SR_CMD_GEN -- requirements
Module: sr_cmd_gen

---
 rtl/sr_cmd_gen.sv | 118 +++++++++++
 1 files changed

// File: rtl/sr_cmd_gen.sv
// rtl/sr_cmd_gen.sv - debounced set/clear buttons to non-overlapping S/R command pulses
// Requests come from the rising debounced level; the FSM serialises them with a one-deep pending flag per type.
module sr_cmd_gen #(
   parameter int DEB_CYCLES = 4,
   parameter int PULSE_LEN  = 1
) (
   input  logic       clk,
   input  logic       n_rst,
   input  logic       set_btn,
   input  logic       clr_btn,
   output logic       S,
   output logic       R,
   output logic       busy,
   output logic       conflict,
   output logic [7:0] cmd_cnt
);

   localparam logic [7:0] DEB_LAST   = 8'(DEB_CYCLES - 1);
   localparam logic [3:0] PULSE_LAST = 4'(PULSE_LEN - 1);

   typedef enum logic [1:0] {IDLE, PULSE_S, PULSE_R, GAP} state_t;

   // index 0 = set button, index 1 = clear button
   logic [1:0] sync1, sync2, deb, rise;
   logic [7:0] deb_cnt [2];

   state_t     state;
   logic       pend_s, pend_r;
   logic [3:0] pcnt;
   logic       want_s, want_r;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         sync1      <= '0;
         sync2      <= '0;
         deb        <= '0;
         deb_cnt[0] <= '0;
         deb_cnt[1] <= '0;
      end else begin
         sync1 <= {clr_btn, set_btn};
         sync2 <= sync1;
         for (int i = 0; i < 2; i++) begin
            if (sync2[i] == deb[i]) begin
               deb_cnt[i] <= '0;
            end else if (deb_cnt[i] == DEB_LAST) begin
               deb[i]     <= sync2[i];
               deb_cnt[i] <= '0;
            end else begin
               deb_cnt[i] <= deb_cnt[i] + 8'd1;
            end
         end
      end
   end

   // Request is taken on the same edge the debounced level rises, which keeps latency at DEB_CYCLES+2.
   always_comb begin
      rise = '0;
      for (int i = 0; i < 2; i++)
         rise[i] = sync2[i] & ~deb[i] & (deb_cnt[i] == DEB_LAST);
   end

   assign want_s = rise[0] | pend_s;
   assign want_r = rise[1] | pend_r;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state    <= IDLE;
         S        <= 1'b0;
         R        <= 1'b0;
         busy     <= 1'b0;
         conflict <= 1'b0;
         cmd_cnt  <= '0;
         pend_s   <= 1'b0;
         pend_r   <= 1'b0;
         pcnt     <= '0;
      end else begin
         conflict <= 1'b0;
         case (state)
            IDLE: begin
               pend_s <= 1'b0;
               pend_r <= 1'b0;
               pcnt   <= PULSE_LAST;
               if (want_r) begin
                  state    <= PULSE_R;
                  R        <= 1'b1;
                  busy     <= 1'b1;
                  conflict <= want_s;
                  cmd_cnt  <= cmd_cnt + 8'd1;
               end else if (want_s) begin
                  state   <= PULSE_S;
                  S       <= 1'b1;
                  busy    <= 1'b1;
                  cmd_cnt <= cmd_cnt + 8'd1;
               end
            end
            PULSE_S, PULSE_R: begin
               pend_s <= pend_s | rise[0];
               pend_r <= pend_r | rise[1];
               if (pcnt == 4'd0) begin
                  state <= GAP;
                  S     <= 1'b0;
                  R     <= 1'b0;
               end else begin
                  pcnt <= pcnt - 4'd1;
               end
            end
            GAP: begin
               pend_s <= pend_s | rise[0];
               pend_r <= pend_r | rise[1];
               state  <= IDLE;
               busy   <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
